serial_cmp: RTL and testbench
=============================

Name: serial_cmp

Overview:
- Multi-cycle 16-bit magnitude comparator; resolves MSB-first, one 4-bit digit per cycle, and terminates early on the first differing digit.
- Produces one-hot lt/eq/gt flags for signed or unsigned operands.
- Sits beside the ALU/branch path as a shared compare engine. Uses a valid/ready handshake on both the input and the output side.

Parameters:
- WIDTH, 16, operand width; must be a multiple of DIGIT.
- DIGIT, 4, bits resolved per cycle.
- NDIG, WIDTH/DIGIT (4), derived digit count; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operand request
- in_ready  out  1  engine can accept operands
- a  in  16  operand A
- b  in  16  operand B
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- a_lt_b  out  1  A < B
- a_eq_b  out  1  A == B
- a_gt_b  out  1  A > B
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset synchronous, active-low on rst_n.
- Reset (rst_n low at a rising edge):
  - state=IDLE; operand registers, digit counter and result flags cleared to 0.
  - out_valid=0, busy=0.
  - in_ready is driven 0 while rst_n is low and is 1 in the first cycle after release.
- Reset mid-operation: the in-flight compare is discarded and no result is produced.
- States:
  - IDLE: in_ready=1.
    - in_valid & in_ready at an edge latches a, b, is_signed; counter=0; -> SCAN.
  - SCAN: in_ready=0.
    - Compare the top DIGIT bits of the shifted A and B registers.
    - Digits differ: latch lt/gt from the digit compare -> DONE.
    - Digits equal and counter==NDIG-1: latch eq -> DONE.
    - Otherwise shift both registers left by DIGIT, counter+1, stay in SCAN.
  - DONE: out_valid=1, in_ready=0.
    - Flags and out_valid held stable while out_ready=0.
    - out_valid & out_ready at an edge -> IDLE.
    - Flags are cleared on leaving DONE.
- Signed handling: at capture, when is_signed=1, bit 15 of both A and B is inverted (bias by 0x8000). The unsigned digit scan then yields the signed order.
- Flags: exactly one of lt/eq/gt is 1 whenever out_valid=1; all three are 0 otherwise.
- Latency, counting from the accepting edge to the edge that raises out_valid:
  - k edges, where k is the 1-based index (from the MSB) of the first differing digit.
  - 4 edges when the operands are equal.
  - Minimum 1, maximum 4.
- Throughput:
  - No same-cycle bypass: in_ready rises in the cycle after the output handshake.
  - Back-to-back operations are therefore separated by at least 1 IDLE cycle.
- in_valid while not in IDLE is ignored; a, b and is_signed are don't-care outside the accepting edge.
- out_ready while out_valid=0 has no effect.
- X-safety: a, b and is_signed are never sampled into state except at the accepting edge.

Decomposition:
- Shared package (cmp_pkg):
  - State enum IDLE=2'b00, SCAN=2'b01, DONE=2'b10.
  - WIDTH, DIGIT, and SIGN_BIAS=16'h8000.
- One sub-module, digit_cmp: combinational, DIGIT-bit unsigned inputs x and y, outputs x_lt and x_gt (eq = neither). Instantiated once on the top digits of the shift registers.

Test Plan:
- a=16'hFFFF, b=16'h0001, is_signed=1 -> out_valid 1 edge after accept, a_lt_b=1 (biased top digits 7 vs 8).
- Same operands, is_signed=0 -> latency 1, a_gt_b=1.
- a=16'h1234, b=16'h1234 -> latency 4, a_eq_b=1; a=16'h1235, b=16'h1234 -> latency 4, a_gt_b=1.
- a=16'h8000, b=16'h7FFF, is_signed=1 -> a_lt_b=1; is_signed=0 -> a_gt_b=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> flags and out_valid stable, in_ready=0. Then pulse out_ready -> out_valid=0 next edge, in_ready=1; new in_valid accepted the following edge.
- Reset: drive rst_n low during SCAN (a=16'h0001, b=16'h0002) -> next edge all outputs 0 and busy=0. After release, in_ready=1 and no stale out_valid appears.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: geometry, sign bias and FSM states.
package cmp_pkg;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    localparam logic [15:0] SIGN_BIAS = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of one digit; equality is signalled by neither flag.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             x_lt,
    output logic             x_gt
);

    assign x_lt = (x < y);
    assign x_gt = (x > y);

endmodule

// File: rtl/serial_cmp.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first differing digit.
// Signed operands are biased at capture so a single unsigned digit scan covers both modes.
module serial_cmp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             busy
);
    import cmp_pkg::*;

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG  = CNT_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state_r, state_s;
    logic [WIDTH-1:0]  a_sh_r, a_sh_s;
    logic [WIDTH-1:0]  b_sh_r, b_sh_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              lt_r, lt_s;
    logic              eq_r, eq_s;
    logic              gt_r, gt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              dig_lt_s;
    logic              dig_gt_s;

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .x    (a_sh_r[WIDTH-1 -: DIGIT]),
        .y    (b_sh_r[WIDTH-1 -: DIGIT]),
        .x_lt (dig_lt_s),
        .x_gt (dig_gt_s)
    );

    // Next-state, datapath shift and result-flag logic.
    always_comb begin
        state_s = state_r;
        a_sh_s  = a_sh_r;
        b_sh_s  = b_sh_r;
        cnt_s   = cnt_r;
        lt_s    = lt_r;
        eq_s    = eq_r;
        gt_s    = gt_r;
        case (state_r)
            IDLE: begin
                // Operands are only looked at on the accepting edge.
                if (in_valid && in_ready_r) begin
                    a_sh_s  = is_signed ? (a ^ SIGN_MASK) : a;
                    b_sh_s  = is_signed ? (b ^ SIGN_MASK) : b;
                    cnt_s   = '0;
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (dig_lt_s || dig_gt_s) begin
                    lt_s    = dig_lt_s;
                    gt_s    = dig_gt_s;
                    state_s = DONE;
                end else if (cnt_r == LAST_DIG) begin
                    eq_s    = 1'b1;
                    state_s = DONE;
                end else begin
                    a_sh_s  = a_sh_r << DIGIT;
                    b_sh_s  = b_sh_r << DIGIT;
                    cnt_s   = cnt_r + CNT_W'(1);
                    state_s = SCAN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    lt_s    = 1'b0;
                    eq_s    = 1'b0;
                    gt_s    = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                lt_s    = 1'b0;
                eq_s    = 1'b0;
                gt_s    = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            cnt_r       <= '0;
            lt_r        <= 1'b0;
            eq_r        <= 1'b0;
            gt_r        <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            a_sh_r      <= a_sh_s;
            b_sh_r      <= b_sh_s;
            cnt_r       <= cnt_s;
            lt_r        <= lt_s;
            eq_r        <= eq_s;
            gt_r        <= gt_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign a_lt_b    = lt_r;
    assign a_eq_b    = eq_r;
    assign a_gt_b    = gt_r;

endmodule

// File: tb/tb_serial_cmp.sv
// Self-checking bench for serial_cmp: directed plan vectors plus randomized operands
// checked against an arithmetic reference model of order and early-exit latency.
module tb_serial_cmp;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic        a_lt_b;
    logic        a_eq_b;
    logic        a_gt_b;
    logic        busy;

    int n_vec;
    int n_err;

    serial_cmp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_lt_b    (a_lt_b),
        .a_eq_b    (a_eq_b),
        .a_gt_b    (a_gt_b),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: order from plain integer arithmetic, latency from the first differing digit.
    task automatic model(input logic [15:0] va, input logic [15:0] vb, input logic s,
                         output logic [2:0] flags, output int lat);
        longint ia, ib;
        logic [15:0] xa, xb;
        ia = s ? longint'($signed(va)) : longint'(va);
        ib = s ? longint'($signed(vb)) : longint'(vb);
        flags = (ia < ib) ? 3'b100 : ((ia == ib) ? 3'b010 : 3'b001);
        xa = s ? (va ^ 16'h8000) : va;
        xb = s ? (vb ^ 16'h8000) : vb;
        lat = 4;
        for (int i = 3; i >= 0; i--) begin
            if (((xa >> (4 * i)) & 16'h000F) != ((xb >> (4 * i)) & 16'h000F)) begin
                lat = 4 - i;
                break;
            end
        end
    endtask

    // One full transaction; all timing is relative to posedge+1.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic s,
                          input int hold, input string tag);
        logic [2:0] exp_f;
        logic [2:0] got_f;
        int exp_lat;
        int lat;
        model(va, vb, s, exp_f, exp_lat);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready_before_accept got=%b want=1", tag, in_ready);
        end
        in_valid = 1'b1; a = va; b = vb; is_signed = s;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_accept busy=%b in_ready=%b want busy=1 in_ready=0", tag, busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        got_f = {a_lt_b, a_eq_b, a_gt_b};
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency a=%h b=%h s=%b got=%0d want=%0d", tag, va, vb, s, lat, exp_lat);
        end
        if (got_f !== exp_f) begin
            n_err++;
            $display("FAIL %s flags(lt,eq,gt) a=%h b=%h s=%b got=%b want=%b", tag, va, vb, s, got_f, exp_f);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {a_lt_b, a_eq_b, a_gt_b} !== exp_f) begin
                n_err++;
                $display("FAIL %s hold%0d out_valid=%b in_ready=%b flags=%b want 1 0 %b",
                         tag, i, out_valid, in_ready, {a_lt_b, a_eq_b, a_gt_b}, exp_f);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            {a_lt_b, a_eq_b, a_gt_b} !== 3'b000) begin
            n_err++;
            $display("FAIL %s release out_valid=%b in_ready=%b busy=%b flags=%b want 0 1 0 000",
                     tag, out_valid, in_ready, busy, {a_lt_b, a_eq_b, a_gt_b});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0000; b = 16'h0000; is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready, out_valid, busy, a_lt_b, a_eq_b, a_gt_b} !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_state got=%b want=000000",
                     {in_ready, out_valid, busy, a_lt_b, a_eq_b, a_gt_b});
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_directed();
        run_op(16'hFFFF, 16'h0001, 1'b1, 0, "neg1_vs_1_signed");
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, "ffff_vs_1_unsigned");
        run_op(16'h1234, 16'h1234, 1'b0, 0, "equal");
        run_op(16'h1235, 16'h1234, 1'b0, 0, "last_digit_gt");
        run_op(16'h8000, 16'h7FFF, 1'b1, 0, "min_vs_max_signed");
        run_op(16'h8000, 16'h7FFF, 1'b0, 0, "8000_vs_7fff_unsigned");
        run_op(16'h8000, 16'h8000, 1'b1, 0, "equal_signed_min");
    endtask

    task automatic test_backpressure();
        run_op(16'h0A00, 16'h0B00, 1'b0, 3, "backpressure");
    endtask

    task automatic test_back_to_back();
        run_op(16'h4321, 16'h4311, 1'b1, 0, "b2b_0");
        run_op(16'hC000, 16'h3000, 1'b1, 1, "b2b_1");
        run_op(16'h0000, 16'hFFFF, 1'b0, 0, "b2b_2");
    endtask

    task automatic test_random();
        logic [15:0] va, vb, mask;
        for (int n = 0; n < 40; n++) begin
            va   = 16'($urandom);
            mask = 16'((32'h1 << (4 * $urandom_range(0, 4))) - 32'h1);
            vb   = (va & ~mask) | (16'($urandom) & mask);
            run_op(va, vb, 1'($urandom), $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_reset_mid_scan();
        n_vec++;
        in_valid = 1'b1; a = 16'h0001; b = 16'h0002; is_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midscan_pre busy=%b out_valid=%b want 1 0", busy, out_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        if ({in_ready, out_valid, busy, a_lt_b, a_eq_b, a_gt_b} !== 6'b000000) begin
            n_err++;
            $display("FAIL midscan_reset got=%b want=000000",
                     {in_ready, out_valid, busy, a_lt_b, a_eq_b, a_gt_b});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midscan_release in_ready got=%b want=1", in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midscan_stale cyc%0d out_valid=%b busy=%b want 0 0", i, out_valid, busy);
            end
            @(posedge clk); #1;
        end
        run_op(16'h0001, 16'h0002, 1'b0, 0, "after_midscan_reset");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
